// File: rtl/ann_pkg.sv
// Shared constants for the ANN datapath blocks and the width helper
// used to size the pipeline occupancy count.
package ann_pkg;

  localparam int ANN_WIDTH    = 4;
  localparam int ANN_CHANNELS = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ann_pipe_stage.sv
// One elastic pipeline stage: a valid flag plus a data word that only
// loads when the stage advances and the incoming word is valid.
module ann_pipe_stage
  import ann_pkg::*;
#(
  parameter int DW = ANN_WIDTH
) (
  input  logic          clo_i,
  input  logic          res_i,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic          prev_valid_i,
  input  logic [DW-1:0] prev_data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // Flush drops the valid flag only; the data word keeps its last value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (adv_i) begin
      valid_d = prev_valid_i;
      if (prev_valid_i) data_d = prev_data_i;
    end
  end

  always_ff @(posedge clo_i or negedge res_i) begin
    if (!res_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ann_pipe_reg.sv
// Elastic multi-lane pipeline register between neuron layers with
// valid/ready back-pressure, bubble collapse and synchronous flush.
module ann_pipe_reg
  import ann_pkg::*;
#(
  parameter int WIDTH    = ANN_WIDTH,
  parameter int CHANNELS = ANN_CHANNELS,
  parameter int DEPTH    = 2,
  localparam int DW      = WIDTH * CHANNELS,
  localparam int OCC_W   = clog2(DEPTH + 1)
) (
  input  logic             clo,
  input  logic             res,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] stage_v;
  logic [DEPTH-1:0] adv;
  logic [DW-1:0]    stage_d [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          pv;
    logic [DW-1:0] pd;

    // A stage may move when downstream drains or any stage from here
    // to the output is empty, which collapses bubbles.
    assign adv[k] = out_ready | ~(&stage_v[DEPTH-1:k]);

    if (k == 0) begin : g_first
      assign pv = in_valid;
      assign pd = in_data;
    end else begin : g_rest
      assign pv = stage_v[k-1];
      assign pd = stage_d[k-1];
    end

    ann_pipe_stage #(.DW(DW)) u_stage (
      .clo_i        (clo),
      .res_i        (res),
      .clr_i        (clr),
      .adv_i        (adv[k]),
      .prev_valid_i (pv),
      .prev_data_i  (pd),
      .valid_o      (stage_v[k]),
      .data_o       (stage_d[k])
    );
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OCC_W'(stage_v[k]);
  end

  assign in_ready  = adv[0] & ~clr;
  assign out_valid = stage_v[DEPTH-1] & ~clr;
  assign out_data  = stage_d[DEPTH-1];

endmodule

// File: tb/tb_ann_pipe_reg.sv
// Scoreboard bench for ann_pipe_reg: a 2-lane 3-deep instance plus a
// 1-lane 1-deep instance sharing clock and reset.
module tb_ann_pipe_reg;

  logic       clo = 1'b0;
  logic       res, clr, clr1;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [1:0] occupancy;
  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [3:0] in_data1, out_data1;
  logic [0:0] occ1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb3 [$];
  logic [3:0] sb1 [$];

  always #5 clo = ~clo;

  ann_pipe_reg #(.WIDTH(4), .CHANNELS(2), .DEPTH(3)) u_d3 (
    .clo(clo), .res(res), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  ann_pipe_reg #(.WIDTH(4), .CHANNELS(1), .DEPTH(1)) u_d1 (
    .clo(clo), .res(res), .clr(clr1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .occupancy(occ1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clo);
    #1;
  endtask

  // Transfers seen mid-cycle complete at the following rising edge.
  always @(negedge clo) begin
    if (!res) begin
      sb3.delete();
      sb1.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb3.size() == 0) chk("sb3_spurious", 32'(sb3.size()), 32'd1);
        else chk("sb3_data", 32'(out_data), 32'(sb3.pop_front()));
      end
      if (in_valid && in_ready) sb3.push_back(in_data);
      if (clr) sb3.delete();
      if (out_valid1 && out_ready1) begin
        if (sb1.size() == 0) chk("sb1_spurious", 32'(sb1.size()), 32'd1);
        else chk("sb1_data", 32'(out_data1), 32'(sb1.pop_front()));
      end
      if (in_valid1 && in_ready1) sb1.push_back(in_data1);
      if (clr1) sb1.delete();
    end
  end

  initial begin
    res = 1'b0; clr = 1'b0; clr1 = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    step(); step();
    res = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // mid-stream asynchronous reset with two words in flight
    step();
    in_valid = 1'b1; in_data = 8'h5A; step();
    in_data = 8'h6B; step();
    in_valid = 1'b0; step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_data", 32'(out_data), 32'h5A);
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    #2 res = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_occ", 32'(occupancy), 32'd0);
    step();
    res = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // streaming with a free-running output
    step();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; #1 chk("strm_rdy0", 32'(in_ready), 32'd1);
    step(); in_data = 8'h22; chk("strm_rdy1", 32'(in_ready), 32'd1);
    step(); in_data = 8'h33; chk("strm_rdy2", 32'(in_ready), 32'd1);
    chk("strm_lat_not_early", 32'(out_valid), 32'd0);
    step();
    chk("strm_v0", 32'(out_valid), 32'd1);
    chk("strm_d0", 32'(out_data), 32'h11);
    in_data = 8'h44; step();
    in_valid = 1'b0;
    chk("strm_d1", 32'(out_data), 32'h22);
    step(); chk("strm_d2", 32'(out_data), 32'h33);
    step(); chk("strm_d3", 32'(out_data), 32'h44);
    step(); chk("strm_empty", 32'(out_valid), 32'd0);

    // back-pressure until full, then simultaneous accept and emit
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA1; step();
    in_data = 8'hA2; step();
    in_data = 8'hA3; step();
    in_data = 8'hA4; #1;
    chk("bp_occ_full", 32'(occupancy), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_data", 32'(out_data), 32'hA1);
    out_ready = 1'b1; #1;
    chk("bp_full_pass_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_after_d", 32'(out_data), 32'hA2);
    chk("bp_after_occ", 32'(occupancy), 32'd3);
    step(); chk("bp_d3", 32'(out_data), 32'hA3);
    step(); chk("bp_d4", 32'(out_data), 32'hA4);
    step(); chk("bp_empty", 32'(out_valid), 32'd0);

    // bubble collapse under back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h05; step();
    in_valid = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 8'h06; step();
    in_valid = 1'b0; step();
    chk("bub_occ", 32'(occupancy), 32'd2);
    chk("bub_in_ready", 32'(in_ready), 32'd1);
    chk("bub_head", 32'(out_data), 32'h05);
    out_ready = 1'b1; step();
    chk("bub_b2b_v", 32'(out_valid), 32'd1);
    chk("bub_b2b_d", 32'(out_data), 32'h06);
    step(); chk("bub_empty", 32'(out_valid), 32'd0);

    // flush with three words resident
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hC1; step();
    in_data = 8'hC2; step();
    in_data = 8'hC3; step();
    in_data = 8'hC4; out_ready = 1'b1; clr = 1'b1; #1;
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    step();
    clr = 1'b0; in_valid = 1'b0; #1;
    chk("clr_occ", 32'(occupancy), 32'd0);
    chk("clr_no_emit", 32'(out_valid), 32'd0);
    chk("clr_data_kept", 32'(out_data), 32'hC1);
    step();
    chk("clr_still_empty", 32'(out_valid), 32'd0);

    // single-stage single-lane instance at full rate
    out_ready1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid1 = 1'b1; in_data1 = 4'(i); #1;
      chk("d1_in_ready", 32'(in_ready1), 32'd1);
      step();
      chk("d1_valid", 32'(out_valid1), 32'd1);
      chk("d1_data", 32'(out_data1), 32'(i));
    end
    in_valid1 = 1'b0; step();
    chk("d1_empty", 32'(out_valid1), 32'd0);

    // random traffic on the 3-deep instance
    for (int i = 0; i < 300; i++) begin
      chk("rnd_occ", 32'(occupancy), 32'(sb3.size()));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_in_ready", 32'(in_ready), 32'(!(sb3.size() == 3 && !out_ready)));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    chk("drain_sb3", 32'(sb3.size()), 32'd0);
    chk("drain_sb1", 32'(sb1.size()), 32'd0);
    chk("drain_occ", 32'(occupancy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ann_pipe_reg.md
Name: ann_pipe_reg

Overview:
Parametrised elastic pipeline register for ANN datapaths. It replaces fixed 4-bit single-stage registers between neuron layers. It carries CHANNELS lanes of WIDTH bits through DEPTH stages and uses a valid/ready handshake, so a stalled downstream layer back-pressures upstream without losing data. Bubbles collapse, and a synchronous flush empties the pipeline.

Parameters:
WIDTH, 4, bits per channel (>=1)
CHANNELS, 1, parallel lanes carried in lock-step (>=1)
DEPTH, 2, number of register stages (>=1)

Ports:
clo  in  1  clock; all state updates on the rising edge
res  in  1  reset, asynchronous, active-low; res=0 clears state immediately
clr  in  1  synchronous flush, active-high
in_valid  in  1  upstream word valid
in_ready  out  1  block accepts a word this cycle
in_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
out_valid  out  1  stage DEPTH-1 holds a word
out_ready  in  1  downstream accepts a word this cycle
out_data  out  CHANNELS*WIDTH  data in stage DEPTH-1
occupancy  out  clog2(DEPTH+1)  number of valid stages

Behaviour:
- Per-stage state: v[k] (1 bit) and d[k] (CHANNELS*WIDTH bits), for k = 0..DEPTH-1. Stage 0 is the input stage; stage DEPTH-1 is the output stage.
- Reset (res=0, asynchronous): all v[k]=0 and all d[k]=0. Consequently out_valid=0, out_data=0, occupancy=0, and in_ready=1 once clr=0. On release, operation resumes at the next rising edge.
- Advance chain (combinational):
  - adv[DEPTH-1] = out_ready | ~v[DEPTH-1]
  - adv[k] = adv[k+1] | ~v[k]
  - in_ready = adv[0] & ~clr
- Update on a clock edge, when clr=0:
  - If adv[k]: v[k] <= v[k-1]; for k=0, v[0] <= in_valid.
  - d[k] loads only when adv[k] and the incoming valid is 1; otherwise d[k] holds its value.
  - If ~adv[k]: stage k holds.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_data is ignored when in_valid=0.
- Latency and throughput: with no stalls, a word accepted at edge N appears on out_data after edge N+DEPTH-1, i.e. DEPTH cycles of register delay. Throughput is 1 word/cycle.
- Full: all v=1 and out_ready=0 gives in_ready=0. Full with out_ready=1 gives in_ready=1, so simultaneous accept and emit is allowed.
- Empty: out_valid=0 and out_data holds its last value.
- Bubbles: an invalid stage always accepts, so gaps collapse under back-pressure.
- Words are never dropped or duplicated, and ordering is preserved.
- out_valid = v[DEPTH-1] and out_data = d[DEPTH-1], driven directly from registers with no combinational path from in_*.
- occupancy = popcount(v); range 0..DEPTH.
- clr=1:
  - In that cycle in_ready and out_valid are forced to 0, so no transfers occur.
  - At the edge all v <= 0; d is unchanged.
  - clr overrides in_valid and out_ready.
- Reset mid-operation: contents are discarded with no handshake; upstream must re-send.
- Channels: all lanes share one valid and one ready, with no per-lane masking.

Decomposition:
- Package ann_pkg: default WIDTH/CHANNELS constants shared with the neuron blocks, and a clog2 constant function for occupancy width.
- Sub-module ann_pipe_stage holds one stage's v/d registers with inputs adv, prev_valid, prev_data. ann_pipe_reg instantiates DEPTH of them in a generate loop and computes the adv chain and popcount.

Test Plan:
Use WIDTH=4, CHANNELS=2, DEPTH=3 unless stated.
1. Reset: drive res=0 mid-stream with 2 words in flight. Required: out_valid=0, out_data=0x00, occupancy=0 immediately without waiting for a clock edge; after release with clr=0, in_ready=1.
2. Streaming: in_valid=1 with in_data=0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=1. Required: out_data=0x11 valid 3 cycles after the first accept, then 0x22, 0x33, 0x44 on consecutive cycles; in_ready stays 1.
3. Back-pressure: out_ready=0, push 0xA1,0xA2,0xA3,0xA4. Required: first three accepted, occupancy=3, in_ready=0 and 0xA4 held upstream. Then set out_ready=1 with in_valid=1. Required: 0xA1 emitted while 0xA4 is accepted in the same cycle, and the output order is A1,A2,A3,A4.
4. Bubble collapse: push 0x05, idle 2 cycles, push 0x06, with out_ready=0. Required: occupancy=2 and in_ready=1; words emerge back-to-back once out_ready=1.
5. Flush: 3 words resident, assert clr=1 with in_valid=1 and out_ready=1. Required: in_ready=0 and out_valid=0 during the clr cycle; next cycle occupancy=0 and nothing is emitted.
6. DEPTH=1, CHANNELS=1 build: in/out simultaneous each cycle. Required: 1-cycle latency, full throughput, values 0x0..0xF stream unchanged.
